// File: rtl/apb_soc_ctrl.sv
// ---------------------------------------------------------------------------
// apb_soc_ctrl -- APB slave holding SoC pad multiplexing / pad configuration,
// the core boot address, a lock against accidental reprogramming and a
// software reset pulse generator.
//
// Optional feature: define APB_SOC_CTRL_LOCK_EN to build the two-key lock FSM
// and write protection. Without it every register is always writable, LOCK
// reads 1 and locked_o is held low.
//
// Ports
//   HCLK, HRESET        clock, synchronous active-high reset
//   PADDR..PENABLE      APB request (register offset taken from PADDR[7:2])
//   PRDATA/PREADY/PSLVERR APB response; every access takes one wait state
//   pad_mux_o           per-pad mux select
//   pad_cfg_o           per-pad config, pad k at [k*PAD_CFG_W +: PAD_CFG_W]
//   boot_addr_o         core boot address
//   soft_rst_o          software reset pulse, SOFT_RST_CYCLES long
//   locked_o            high while protected registers reject writes
//
// Register map (offset):
//   0x00 PAD_MUX   0x04 BOOT_ADR   0x08 INFO (RO)   0x0C LOCK
//   0x10 SOFT_RST  0x20+4k PADCFGk, byte lane j -> pad 4k+j
// ---------------------------------------------------------------------------
module apb_soc_ctrl #(
  parameter int          APB_ADDR_WIDTH  = 12,
  parameter int          N_PADS          = 32,
  parameter int          PAD_CFG_W       = 6,
  parameter logic [31:0] BOOT_ADDR       = 32'h8000,
  parameter int          SOFT_RST_CYCLES = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
  input  logic [31:0]                   PWDATA,
  input  logic                          PWRITE,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  output logic [31:0]                   PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [N_PADS-1:0]             pad_mux_o,
  output logic [N_PADS*PAD_CFG_W-1:0]   pad_cfg_o,
  output logic [31:0]                   boot_addr_o,
  output logic                          soft_rst_o,
  output logic                          locked_o
);

  localparam int          NCFG     = (N_PADS + 3) / 4;
  localparam logic [31:0] INFO_VAL = {16'h0, 8'(N_PADS), 4'(PAD_CFG_W), 4'h2};

  logic [5:0]   off;
  logic         access, wait_q, xfer, wr;
  logic         sel_mux, sel_boot, sel_info, sel_lock, sel_srst, sel_cfg;
  logic         unlocked, busy, err, srst_go;
  logic [31:0]  rdata;
  logic [7:0]   cnt;
  logic [255:0] cfg_rd;
  logic         unused_addr;

  // Only PADDR[7:2] selects a register; the rest of the address is don't-care.
  assign off         = PADDR[7:2];
  assign unused_addr = ^PADDR;

  assign sel_mux  = (off == 6'd0);
  assign sel_boot = (off == 6'd1);
  assign sel_info = (off == 6'd2);
  assign sel_lock = (off == 6'd3);
  assign sel_srst = (off == 6'd4);
  assign sel_cfg  = (int'(off) >= 8) && (int'(off) < 8 + NCFG);

  // ---------------------------------------------------------------------------
  // APB handshake: the first access cycle sets wait_q, the second completes.
  // wait_q falls whenever the access phase ends (PSEL or PENABLE low), so each
  // transfer, including back-to-back ones, gets exactly one wait state.
  // ---------------------------------------------------------------------------
  assign access = PSEL & PENABLE;

  always_ff @(posedge HCLK) begin
    if (HRESET) wait_q <= 1'b0;
    else        wait_q <= access & ~wait_q;
  end

  assign PREADY  = access & wait_q & ~HRESET;
  assign xfer    = PREADY;
  assign wr      = xfer & PWRITE;
  assign PRDATA  = (xfer & ~PWRITE) ? rdata : 32'h0;
  assign PSLVERR = xfer & err;

  // ---------------------------------------------------------------------------
  // Lock state
  // ---------------------------------------------------------------------------
`ifdef APB_SOC_CTRL_LOCK_EN
  typedef enum logic [1:0] {LOCKED, KEY1, UNLOCKED} lock_state_t;
  lock_state_t state, state_nxt;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= LOCKED;
    else        state <= state_nxt;
  end

  // Only completed writes move the FSM; reads leave a half-entered key alone.
  always_comb begin
    state_nxt = state;
    if (wr) begin
      case (state)
        LOCKED:   if (sel_lock && PWDATA == 32'hA5) state_nxt = KEY1;
        KEY1:     state_nxt = (sel_lock && PWDATA == 32'h5A) ? UNLOCKED : LOCKED;
        UNLOCKED: if (sel_lock) state_nxt = LOCKED;
        default:  state_nxt = LOCKED;
      endcase
    end
  end

  assign unlocked = (state == UNLOCKED);
  assign locked_o = ~unlocked;
`else
  assign unlocked = 1'b1;
  assign locked_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and error decode
  // ---------------------------------------------------------------------------
  // Pad configs spread onto byte lanes, unused bits and missing pads zero.
  always_comb begin
    cfg_rd = '0;
    for (int p = 0; p < N_PADS; p++)
      cfg_rd[p*8 +: PAD_CFG_W] = pad_cfg_o[p*PAD_CFG_W +: PAD_CFG_W];
  end

  always_comb begin
    rdata = 32'h0;
    err   = 1'b0;
    if (sel_mux) begin
      rdata = 32'(pad_mux_o);
      err   = PWRITE & ~unlocked;
    end else if (sel_boot) begin
      rdata = boot_addr_o;
      err   = PWRITE & ~unlocked;
    end else if (sel_info) begin
      rdata = INFO_VAL;
      err   = PWRITE;
    end else if (sel_lock) begin
      // Lock-less builds report permanently unlocked (reads 1).
      rdata = {31'b0, unlocked};
    end else if (sel_srst) begin
      rdata = {31'b0, busy};
      err   = PWRITE & ~unlocked;
    end else if (sel_cfg) begin
      rdata = cfg_rd[int'(off[2:0])*32 +: 32];
      err   = PWRITE & ~unlocked;
    end else begin
      err   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pad_mux_o   <= '0;
      pad_cfg_o   <= '0;
      boot_addr_o <= BOOT_ADDR;
    end else if (wr && !err) begin
      if (sel_mux)  pad_mux_o   <= PWDATA[N_PADS-1:0];
      if (sel_boot) boot_addr_o <= PWDATA;
      if (sel_cfg) begin
        for (int p = 0; p < N_PADS; p++)
          if (off[2:0] == 3'(p / 4))
            pad_cfg_o[p*PAD_CFG_W +: PAD_CFG_W] <= PWDATA[(p % 4)*8 +: PAD_CFG_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Soft reset pulse: a down-counter loaded on trigger; soft_rst_o is its own
  // flop, held high while the counter has more than one cycle left.
  // ---------------------------------------------------------------------------
  assign busy    = (cnt != 8'd0);
  assign srst_go = wr & sel_srst & ~err & PWDATA[0] & ~busy;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt        <= 8'd0;
      soft_rst_o <= 1'b0;
    end else if (srst_go) begin
      cnt        <= 8'(SOFT_RST_CYCLES);
      soft_rst_o <= 1'b1;
    end else if (busy) begin
      cnt        <= cnt - 8'd1;
      soft_rst_o <= (cnt > 8'd1);
    end
  end

endmodule
